// File: rtl/mem_block_ctrl.sv
// Request-side controller for the 512x32 block memory: one 16-word burst load or
// store per request, strobe sequencing, read-data capture and a single response.
module mem_block_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 16,
    parameter int unsigned DEPTH  = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WORDS*WORD_W-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_err,
    output logic [WORDS*WORD_W-1:0]   resp_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic                      mem_oe,
    output logic [WORDS*WORD_W-1:0]   mem_din,
    input  logic [WORDS*WORD_W-1:0]   mem_dout
);

    localparam int unsigned BLK_W = WORDS * WORD_W;
    localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(DEPTH - WORDS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_CAP   = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       accept;
    logic       range_err;

    assign accept    = (state == S_IDLE) && req_valid;
    assign range_err = (req_addr > MAX_BASE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (range_err) begin
                        state_nxt = S_RESP;
                    end else if (req_write) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_WR:       state_nxt = S_RESP;
            S_RD_ISSUE: state_nxt = S_RD_CAP;
            S_RD_CAP:   state_nxt = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strobes and handshakes are registered decodes of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            req_ready  <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            mem_we     <= (state_nxt == S_WR);
            mem_oe     <= (state_nxt == S_RD_ISSUE) || (state_nxt == S_RD_CAP);
            resp_valid <= (state_nxt == S_RESP);
        end
    end

    // Request latches and read-data capture; rdata only moves on a completed load
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                mem_addr <= req_addr;
                mem_din  <= req_wdata;
                resp_err <= range_err;
            end
            if (state == S_RD_CAP) begin
                resp_rdata <= BLK_W'(mem_dout);
            end
        end
    end

endmodule
